alu_port_arbiter: RTL and testbench

- Shares the single-cycle combinational ALU between two requesters: port 0 is the execute stage, port 1 is the address-generation/debug path.
- Accepts one operation at a time over a valid/ready handshake, chosen by round-robin or fixed priority.
- Drives the ALU operand and control inputs from registers, captures the ALU result, and returns it to the granted port over a valid/ready response handshake.
- Rejects opcodes the ALU does not implement without issuing them to the ALU.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_port_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter2.sv | 52 +++++
 rtl/alu_port_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU port arbiter: opcodes, FSM encoding and
// default datapath widths.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB = 3'd6;
    localparam logic [OP_W-1:0] OP_MIN = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Codes 3..5 have no ALU implementation and must never reach ALU_control.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MIN: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_port_arbiter_if.sv
// Request/response handshakes of both ports plus the ALU operand/result wires.
interface alu_port_arbiter_if #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
);
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req0_op;
    logic [OP_W-1:0]   req1_op;
    logic              resp0_valid;
    logic              resp1_valid;
    logic              resp0_ready;
    logic              resp1_ready;
    logic [DATA_W-1:0] resp_result;
    logic              resp_err;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, resp0_ready, resp1_ready, alu_result,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp_result, resp_err, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, resp0_ready, resp1_ready, alu_result,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp_result, resp_err, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant: round-robin pointer advanced on a completion strobe, or fixed
// priority to port 0 when FIXED_PRIO is set.
module rr_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       done_port_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // One-hot grant; a lone requester wins regardless of the pointer.
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = (FIXED_PRIO || !ptr_q) ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end else begin
            grant_o = 2'b00;
        end
    end

    // After a completion the pointer favours the port that was not just served.
    always_comb begin
        ptr_d = ptr_q;
        if (done_i && !FIXED_PRIO) begin
            ptr_d = ~done_port_i;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_port_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE accepts, EXEC drives
// the ALU for one cycle, RESP holds the result until the granted port takes it.
module alu_port_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int OP_W       = alu_pkg::OP_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    alu_port_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;
    logic              resp_err_q, resp_err_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;

    logic [1:0]        grant_s;
    logic              done_s;
    logic [OP_W-1:0]   op_sel_s;
    logic              resp_ready_s;

    rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        ((state_q == ST_IDLE) && rst_n),
        .req_i       ({bus.req1_valid, bus.req0_valid}),
        .done_i      (done_s),
        .done_port_i (grant_q),
        .grant_o     (grant_s)
    );

    assign op_sel_s     = grant_s[1] ? bus.req1_op : bus.req0_op;
    assign resp_ready_s = grant_q ? bus.resp1_ready : bus.resp0_ready;

    // Next-state and next-output logic for the accept/execute/respond sequence.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        illegal_d     = illegal_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        done_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    grant_d    = grant_s[1];
                    alu_a_d    = grant_s[1] ? bus.req1_a : bus.req0_a;
                    alu_b_d    = grant_s[1] ? bus.req1_b : bus.req0_b;
                    illegal_d  = !is_legal_op(op_sel_s);
                    alu_ctrl_d = is_legal_op(op_sel_s) ? op_sel_s : {OP_W{1'b0}};
                    state_d    = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                resp_result_d = illegal_q ? {DATA_W{1'b0}} : bus.alu_result;
                resp_err_d    = illegal_q;
                alu_a_d       = {DATA_W{1'b0}};
                alu_b_d       = {DATA_W{1'b0}};
                alu_ctrl_d    = {OP_W{1'b0}};
                resp0_valid_d = !grant_q;
                resp1_valid_d = grant_q;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_s) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    done_s        = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                alu_a_d       = {DATA_W{1'b0}};
                alu_b_d       = {DATA_W{1'b0}};
                alu_ctrl_d    = {OP_W{1'b0}};
                resp0_valid_d = 1'b0;
                resp1_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            illegal_q     <= 1'b0;
            alu_a_q       <= {DATA_W{1'b0}};
            alu_b_q       <= {DATA_W{1'b0}};
            alu_ctrl_q    <= {OP_W{1'b0}};
            resp_result_q <= {DATA_W{1'b0}};
            resp_err_q    <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            illegal_q     <= illegal_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    assign bus.req0_ready  = grant_s[0];
    assign bus.req1_ready  = grant_s[1];
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp1_valid = resp1_valid_q;

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Bench for alu_port_arbiter: a round-robin and a fixed-priority instance, each
// next to a behavioural ALU, checked every cycle against a transaction model.
module tb_alu_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
    logic [2:0]  op0 = 3'd0, op1 = 3'd0;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    alu_port_arbiter_if #(.DATA_W(32), .OP_W(3)) if_rr ();
    alu_port_arbiter_if #(.DATA_W(32), .OP_W(3)) if_fp ();

    alu_port_arbiter #(.DATA_W(32), .OP_W(3), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
    alu_port_arbiter #(.DATA_W(32), .OP_W(3), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(if_fp.slave));

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return (a < b) ? a : b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic legal(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd6) || (op == 3'd7);
    endfunction

    // ALUs beside each arbiter
    assign if_rr.alu_result = alu_fn(if_rr.alu_ctrl, if_rr.alu_a, if_rr.alu_b);
    assign if_fp.alu_result = alu_fn(if_fp.alu_ctrl, if_fp.alu_a, if_fp.alu_b);

    // Stimulus goes to the selected instance; the other sits idle.
    assign if_rr.req0_valid = !sel && v0;   assign if_fp.req0_valid = sel && v0;
    assign if_rr.req1_valid = !sel && v1;   assign if_fp.req1_valid = sel && v1;
    assign if_rr.resp0_ready = !sel && rr0; assign if_fp.resp0_ready = sel && rr0;
    assign if_rr.resp1_ready = !sel && rr1; assign if_fp.resp1_ready = sel && rr1;
    assign if_rr.req0_a = a0; assign if_rr.req0_b = b0; assign if_rr.req0_op = op0;
    assign if_rr.req1_a = a1; assign if_rr.req1_b = b1; assign if_rr.req1_op = op1;
    assign if_fp.req0_a = a0; assign if_fp.req0_b = b0; assign if_fp.req0_op = op0;
    assign if_fp.req1_a = a1; assign if_fp.req1_b = b1; assign if_fp.req1_op = op1;

    logic        o_rdy0, o_rdy1, o_rv0, o_rv1, o_err;
    logic [31:0] o_res, o_aa, o_ab;
    logic [2:0]  o_ctrl;
    assign o_rdy0 = sel ? if_fp.req0_ready  : if_rr.req0_ready;
    assign o_rdy1 = sel ? if_fp.req1_ready  : if_rr.req1_ready;
    assign o_rv0  = sel ? if_fp.resp0_valid : if_rr.resp0_valid;
    assign o_rv1  = sel ? if_fp.resp1_valid : if_rr.resp1_valid;
    assign o_res  = sel ? if_fp.resp_result : if_rr.resp_result;
    assign o_err  = sel ? if_fp.resp_err    : if_rr.resp_err;
    assign o_aa   = sel ? if_fp.alu_a       : if_rr.alu_a;
    assign o_ab   = sel ? if_fp.alu_b       : if_rr.alu_b;
    assign o_ctrl = sel ? if_fp.alu_ctrl    : if_rr.alu_ctrl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Transaction model: one op in flight, age counts cycles since acceptance.
    logic        m_busy = 1'b0, m_port = 1'b0, m_ptr = 1'b0, m_after_rst = 1'b0;
    int          m_age = 0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
    logic [2:0]  m_op = 3'd0;

    function automatic int winner();
        if (!rst_n || m_busy || !(v0 || v1)) return -1;
        if (v0 && v1) return (sel || !m_ptr) ? 0 : 1;
        return v0 ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        m_after_rst <= !rst_n;
        if (!rst_n) begin
            m_busy <= 1'b0; m_age <= 0; m_ptr <= 1'b0;
        end else if (!m_busy) begin
            if (winner() >= 0) begin
                m_busy <= 1'b1; m_age <= 1;
                m_port <= (winner() == 1);
                m_a  <= (winner() == 1) ? a1 : a0;
                m_b  <= (winner() == 1) ? b1 : b0;
                m_op <= (winner() == 1) ? op1 : op0;
                m_res <= (winner() == 1) ? (legal(op1) ? alu_fn(op1, a1, b1) : 32'd0)
                                         : (legal(op0) ? alu_fn(op0, a0, b0) : 32'd0);
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (m_port ? rr1 : rr0) begin
            m_busy <= 1'b0; m_age <= 0;
            if (!sel) m_ptr <= !m_port;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic exec, resp;
        exec = m_busy && (m_age == 1);
        resp = m_busy && (m_age == 2);
        chk("req0_ready", {31'd0, o_rdy0}, {31'd0, winner() == 0});
        chk("req1_ready", {31'd0, o_rdy1}, {31'd0, winner() == 1});
        chk("alu_a", o_aa, exec ? m_a : 32'd0);
        chk("alu_b", o_ab, exec ? m_b : 32'd0);
        chk("alu_ctrl", {29'd0, o_ctrl}, {29'd0, (exec && legal(m_op)) ? m_op : 3'd0});
        chk("resp0_valid", {31'd0, o_rv0}, {31'd0, resp && !m_port});
        chk("resp1_valid", {31'd0, o_rv1}, {31'd0, resp && m_port});
        if (resp) begin
            chk("resp_result", o_res, m_res);
            chk("resp_err", {31'd0, o_err}, {31'd0, !legal(m_op)});
        end
        if (m_after_rst) begin
            chk("rst_result", o_res, 32'd0);
            chk("rst_err", {31'd0, o_err}, 32'd0);
        end
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic at_neg(); @(negedge clk); endtask

    task automatic do_reset(input logic s);
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0; sel = s;
        step(); step();
        rst_n = 1'b1;
    endtask

    int gq[$];
    int rq[$];

    initial begin
        // Reset state
        do_reset(1'b0);
        at_neg();
        chk("lit_rst_rdy0", {31'd0, o_rdy0}, 32'd0);
        chk("lit_rst_rv0", {31'd0, o_rv0}, 32'd0);
        chk("lit_rst_ctrl", {29'd0, o_ctrl}, 32'd0);

        // Single ADD: ready in N, ctrl=2 in N+1, response in N+2
        step();
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 3'd2; rr0 = 1'b1;
        at_neg(); chk("lit_add_ready", {31'd0, o_rdy0}, 32'd1);
        step(); v0 = 1'b0;
        at_neg(); chk("lit_add_ctrl", {29'd0, o_ctrl}, 32'd2);
        step();
        at_neg(); chk("lit_add_rv", {31'd0, o_rv0}, 32'd1);
        chk("lit_add_res", o_res, 32'd8);
        chk("lit_add_err", {31'd0, o_err}, 32'd0);
        step();
        at_neg(); chk("lit_add_ctrl_off", {29'd0, o_ctrl}, 32'd0);

        // Round-robin tie
        do_reset(1'b0);
        v0 = 1'b1; a0 = 32'd10; b0 = 32'd4; op0 = 3'd6;
        v1 = 1'b1; a1 = 32'hF0; b1 = 32'h3C; op1 = 3'd0; rr0 = 1'b1; rr1 = 1'b1;
        gq.delete(); rq.delete();
        for (int c = 0; c < 12; c++) begin
            at_neg();
            if (o_rdy0) gq.push_back(0);
            if (o_rdy1) gq.push_back(1);
            if (o_rv0 || o_rv1) rq.push_back(int'(o_res));
            step();
        end
        chk("lit_rr_ngrants", gq.size(), 32'd4);
        chk("lit_rr_nres", rq.size(), 32'd4);
        if (gq.size() == 4) begin
            chk("lit_rr_g0", gq[0], 32'd0); chk("lit_rr_g1", gq[1], 32'd1);
            chk("lit_rr_g2", gq[2], 32'd0); chk("lit_rr_g3", gq[3], 32'd1);
        end
        if (rq.size() == 4) begin
            chk("lit_rr_r0", rq[0], 32'd6); chk("lit_rr_r1", rq[1], 32'h30);
        end

        // Backpressure on port 1
        do_reset(1'b0);
        v1 = 1'b1; a1 = 32'd9; b1 = 32'd2; op1 = 3'd7; rr1 = 1'b0;
        a0 = 32'd1; b0 = 32'd1; op0 = 3'd2; rr0 = 1'b1;
        at_neg(); chk("lit_bp_acc", {31'd0, o_rdy1}, 32'd1);
        step(); v1 = 1'b0; v0 = 1'b1;
        at_neg();
        step();
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("lit_bp_rv1", {31'd0, o_rv1}, 32'd1);
            chk("lit_bp_res", o_res, 32'd2);
            chk("lit_bp_rdy0", {31'd0, o_rdy0}, 32'd0);
            step();
        end
        rr1 = 1'b1;
        at_neg(); chk("lit_bp_rv1_last", {31'd0, o_rv1}, 32'd1);
        step(); rr1 = 1'b0;
        at_neg(); chk("lit_bp_rdy0_after", {31'd0, o_rdy0}, 32'd1);
        step(); v0 = 1'b0;
        step(); step(); step();

        // Illegal opcode
        do_reset(1'b0);
        v0 = 1'b1; a0 = 32'hFF; b0 = 32'h0F; op0 = 3'd4; rr0 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("lit_ill_ctrl", {29'd0, o_ctrl}, 32'd0);
            if (c == 2) begin
                chk("lit_ill_rv", {31'd0, o_rv0}, 32'd1);
                chk("lit_ill_err", {31'd0, o_err}, 32'd1);
                chk("lit_ill_res", o_res, 32'd0);
            end
            step();
            v0 = 1'b0;
        end

        // Fixed priority instance
        do_reset(1'b1);
        v0 = 1'b1; a0 = 32'd1; b0 = 32'd1; op0 = 3'd2;
        v1 = 1'b1; a1 = 32'h10; b1 = 32'h01; op1 = 3'd1; rr0 = 1'b1; rr1 = 1'b1;
        gq.delete();
        for (int c = 0; c < 9; c++) begin
            at_neg();
            if (o_rdy0) gq.push_back(0);
            if (o_rdy1) gq.push_back(1);
            step();
        end
        chk("lit_fp_ngrants", gq.size(), 32'd3);
        if (gq.size() == 3) begin
            chk("lit_fp_g0", gq[0], 32'd0); chk("lit_fp_g1", gq[1], 32'd0);
            chk("lit_fp_g2", gq[2], 32'd0);
        end
        v0 = 1'b0;
        at_neg(); chk("lit_fp_port1", {31'd0, o_rdy1}, 32'd1);
        step(); v1 = 1'b0;
        step(); step(); step();

        // Reset during EXEC
        do_reset(1'b0);
        v1 = 1'b1; a1 = 32'd3; b1 = 32'd4; op1 = 3'd2; rr1 = 1'b1;
        at_neg(); chk("lit_mr_acc", {31'd0, o_rdy1}, 32'd1);
        step(); v1 = 1'b0; rst_n = 1'b0;
        at_neg();
        step();
        at_neg();
        chk("lit_mr_rv1", {31'd0, o_rv1}, 32'd0);
        chk("lit_mr_ctrl", {29'd0, o_ctrl}, 32'd0);
        chk("lit_mr_alua", o_aa, 32'd0);
        chk("lit_mr_res", o_res, 32'd0);
        step();
        rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 32'd7; b0 = 32'd2; op0 = 3'd6; rr0 = 1'b1;
        at_neg();
        chk("lit_mr_tie0", {31'd0, o_rdy0}, 32'd1);
        chk("lit_mr_tie1", {31'd0, o_rdy1}, 32'd0);
        step(); v0 = 1'b0; v1 = 1'b0;
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
